obi_mem_arbiter: RTL and testbench

- Shares one single-ported OBI memory between the core's instruction and data OBI interfaces.
- Used to build a unified-memory variant of the core top.
- Arbitrates address phases round-robin and locks the selection until grant.
- Tracks outstanding transactions in an in-order owner FIFO and routes each response (rvalid/rdata) back to the requester that issued it.

---
 rtl/obi_mem_arbiter.sv | 100 ++++++++++
 tb/tb_obi_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: shares one single-ported OBI memory between instruction and data ports
module obi_mem_arbiter #(
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_req_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  input  logic [31:0]      instr_addr_i,
  output logic [31:0]      instr_rdata_o,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  input  logic [31:0]      data_addr_i,
  input  logic [3:0]       data_be_i,
  input  logic             data_we_i,
  input  logic [31:0]      data_wdata_i,
  output logic [31:0]      data_rdata_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  output logic [31:0]      mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             spurious_rvalid_o
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                       lock_q, lock_d, lock_sel_q, lock_sel_d, rr_q, rr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MAX_OUTSTANDING-1:0] own_q, own_d;
  logic                       full, sel, sel_req, accept, pop, head;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Selection (1 = data): held while locked, else single requester or round-robin pointer
  always_comb begin
    full    = cnt_q == CNT_W'(MAX_OUTSTANDING);
    sel     = lock_q ? lock_sel_q : (instr_req_i && data_req_i) ? rr_q : data_req_i;
    sel_req = sel ? data_req_i : instr_req_i;
    accept  = sel_req & ~full & mem_gnt_i;
    pop     = mem_rvalid_i & (cnt_q != '0);
    head    = own_q[rptr_q];
  end

  assign mem_req_o         = sel_req & ~full;
  assign mem_addr_o        = sel ? data_addr_i : instr_addr_i;
  assign mem_be_o          = sel ? data_be_i : 4'hF;
  assign mem_we_o          = sel & data_we_i;
  assign mem_wdata_o       = sel ? data_wdata_i : 32'h0;
  assign instr_gnt_o       = accept & ~sel;
  assign data_gnt_o        = accept & sel;
  assign instr_rvalid_o    = pop & ~head;
  assign data_rvalid_o     = pop & head;
  assign instr_rdata_o     = mem_rdata_i;
  assign data_rdata_o      = mem_rdata_i;
  assign outstanding_o     = cnt_q;
  assign spurious_rvalid_o = mem_rvalid_i & (cnt_q == '0);

  // Next state: lock on stalled request, flip priority on accept, push/pop owner FIFO
  always_comb begin
    lock_d     = mem_req_o & ~mem_gnt_i;
    lock_sel_d = sel;
    rr_d       = accept ? ~sel : rr_q;
    own_d      = own_q;
    if (accept) own_d[wptr_q] = sel;
    wptr_d     = accept ? inc(wptr_q) : wptr_q;
    rptr_d     = pop ? inc(rptr_q) : rptr_q;
    cnt_d      = cnt_q + CNT_W'(accept) - CNT_W'(pop);
  end

  // State registers; reset empties the FIFO, clears lock and favours data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      rr_q       <= 1'b1;
      own_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      rr_q       <= rr_d;
      own_q      <= own_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: directed scoreboard bench for the instruction/data memory arbiter
module tb_obi_mem_arbiter;
  logic        clk = 0, rst_ni = 0;
  logic        instr_req_i = 0, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i = 0, instr_rdata_o;
  logic        data_req_i = 0, data_gnt_o, data_rvalid_o;
  logic [31:0] data_addr_i = 0, data_wdata_i = 0, data_rdata_o;
  logic [3:0]  data_be_i = 0;
  logic        data_we_i = 0;
  logic        mem_req_o, mem_gnt_i = 0, mem_rvalid_i = 0, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 0;
  logic [3:0]  mem_be_o;
  logic [1:0]  outstanding_o;
  logic        spurious_rvalid_o;

  int compared = 0, mismatched = 0;
  logic [32:0] gnt_q[$];
  logic [32:0] rsp_q[$];

  obi_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_addr_i(data_addr_i), .data_be_i(data_be_i), .data_we_i(data_we_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .outstanding_o(outstanding_o), .spurious_rvalid_o(spurious_rvalid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic dr, input logic g, input logic rv, input logic [31:0] rd);
    instr_req_i  = ir;
    data_req_i   = dr;
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
  endtask

  // Grant monitor: each grant must match the next expected {owner, address}
  initial forever begin
    @(negedge clk);
    if (instr_gnt_o || data_gnt_o) begin
      if (gnt_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_gnt: got instr=%b data=%b expected none", instr_gnt_o, data_gnt_o);
      end else begin
        logic [32:0] e;
        e = gnt_q.pop_front();
        chk("gnt_owner", {31'b0, data_gnt_o}, {31'b0, e[32]});
        chk("gnt_onehot", {31'b0, instr_gnt_o & data_gnt_o}, 32'h0);
        chk("gnt_addr", mem_addr_o, e[31:0]);
      end
    end
  end

  // Response monitor: each rvalid must match the next expected {owner, rdata}
  initial forever begin
    @(negedge clk);
    if (instr_rvalid_o || data_rvalid_o) begin
      if (rsp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rvalid: got instr=%b data=%b expected none", instr_rvalid_o, data_rvalid_o);
      end else begin
        logic [32:0] e;
        e = rsp_q.pop_front();
        chk("rsp_owner", {30'b0, instr_rvalid_o, data_rvalid_o}, {30'b0, ~e[32], e[32]});
        chk("rsp_rdata", e[32] ? data_rdata_o : instr_rdata_o, e[31:0]);
      end
    end
  end

  initial begin
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req_o}, 0);
    chk("rst_gnts", {30'b0, instr_gnt_o, data_gnt_o}, 0);
    chk("rst_rvalids", {30'b0, instr_rvalid_o, data_rvalid_o}, 0);
    chk("rst_outstanding", {30'b0, outstanding_o}, 0);
    chk("rst_spurious", {31'b0, spurious_rvalid_o}, 0);
    tick();
    rst_ni = 1;
    tick();
    // Instruction only
    instr_addr_i = 32'h0002_0000;
    drive(1, 0, 1, 0, 0);
    gnt_q.push_back({1'b0, 32'h0002_0000});
    @(negedge clk);
    chk("instr_be", {28'b0, mem_be_o}, 32'hF);
    chk("instr_we", {31'b0, mem_we_o}, 0);
    chk("instr_wdata", mem_wdata_o, 0);
    tick();
    drive(0, 0, 0, 1, 32'hDEAD_BEEF);
    rsp_q.push_back({1'b0, 32'hDEAD_BEEF});
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    // Contention: data first, then alternating; responses one cycle later
    instr_addr_i = 32'h0000_0100;
    data_addr_i  = 32'h1000_0000;
    data_be_i    = 4'h3;
    data_we_i    = 1;
    data_wdata_i = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, i < 4, i < 4, i > 0, 32'hA0 + i);
      if (i < 4) gnt_q.push_back({i[0] == 0, (i[0] == 0) ? 32'h1000_0000 : 32'h0000_0100});
      if (i > 0) rsp_q.push_back({i[0] == 1, 32'hA0 + i});
      if (i == 0) begin
        @(negedge clk);
        chk("data_be", {28'b0, mem_be_o}, 32'h3);
        chk("data_we", {31'b0, mem_we_o}, 1);
        chk("data_wdata", mem_wdata_o, 32'h1234_5678);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    // Lock: data selected but stalled three cycles, then data, then instr
    data_addr_i = 32'h1000_0004;
    data_we_i   = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0);
      @(negedge clk);
      chk("lock_addr", mem_addr_o, 32'h1000_0004);
      chk("lock_req", {31'b0, mem_req_o}, 1);
      tick();
    end
    drive(1, 1, 1, 0, 0);
    gnt_q.push_back({1'b1, 32'h1000_0004});
    tick();
    drive(1, 0, 1, 1, 32'hB0);
    gnt_q.push_back({1'b0, 32'h0000_0100});
    rsp_q.push_back({1'b1, 32'hB0});
    tick();
    drive(0, 0, 0, 1, 32'hB1);
    rsp_q.push_back({1'b0, 32'hB1});
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lock_outstanding_end", {30'b0, outstanding_o}, 0);
    tick();
    // Full: two accepts with no response
    drive(1, 0, 1, 0, 0);
    gnt_q.push_back({1'b0, 32'h0000_0100});
    gnt_q.push_back({1'b0, 32'h0000_0100});
    tick();
    tick();
    @(negedge clk);
    chk("full_outstanding", {30'b0, outstanding_o}, 2);
    chk("full_mem_req", {31'b0, mem_req_o}, 0);
    tick();
    drive(1, 0, 1, 1, 32'hC0);
    rsp_q.push_back({1'b0, 32'hC0});
    @(negedge clk);
    chk("full_pop_still_blocked", {31'b0, mem_req_o}, 0);
    tick();
    // Count 1: accept and response together
    drive(1, 0, 1, 1, 32'hC1);
    gnt_q.push_back({1'b0, 32'h0000_0100});
    rsp_q.push_back({1'b0, 32'hC1});
    @(negedge clk);
    chk("reopen_outstanding", {30'b0, outstanding_o}, 1);
    chk("reopen_mem_req", {31'b0, mem_req_o}, 1);
    tick();
    drive(0, 0, 0, 1, 32'hC2);
    rsp_q.push_back({1'b0, 32'hC2});
    @(negedge clk);
    chk("pushpop_outstanding", {30'b0, outstanding_o}, 1);
    chk("pushpop_no_spurious", {31'b0, spurious_rvalid_o}, 0);
    tick();
    // Spurious response with empty FIFO
    drive(0, 0, 0, 1, 32'hC3);
    @(negedge clk);
    chk("spurious_pulse", {31'b0, spurious_rvalid_o}, 1);
    chk("spurious_no_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("spurious_one_cycle", {31'b0, spurious_rvalid_o}, 0);
    chk("spurious_state", {30'b0, outstanding_o}, 0);
    tick();
    // Reset mid-flight with two outstanding
    drive(0, 1, 1, 0, 0);
    gnt_q.push_back({1'b1, 32'h1000_0004});
    gnt_q.push_back({1'b1, 32'h1000_0004});
    tick();
    tick();
    drive(0, 0, 0, 0, 0);
    chk("pre_reset_outstanding", {30'b0, outstanding_o}, 2);
    #2 rst_ni = 0;
    #1;
    chk("async_rst_outstanding", {30'b0, outstanding_o}, 0);
    chk("async_rst_mem_req", {31'b0, mem_req_o}, 0);
    tick();
    rst_ni = 1;
    drive(0, 0, 0, 1, 32'hD0);
    @(negedge clk);
    chk("post_rst_spurious", {31'b0, spurious_rvalid_o}, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("gnt_queue_drained", gnt_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
